pll_reset_sequencer: RTL

Consumer end of the iCE40 PLL wrapper: takes the PLL `locked` flag and generates the datapath reset for the 201 MHz domain. Runs on the PLL output clock. Holds `reset_out_n` low until lock has been continuously stable for a programmable time plus a hold interval. Re-asserts reset immediately on loss of lock and keeps saturating diagnostic counters for the SDR status registers.

---
 rtl/pll_reset_sequencer_if.sv | 31 +++
 rtl/pll_reset_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL lock source / SDR status readback and the reset sequencer.
// The sequencer side uses the slave modport; whoever drives lock and soft reset uses master.
interface pll_reset_sequencer_if;
  logic       locked;
  logic       soft_reset;
  logic       reset_out_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_loss_count;
  logic [7:0] glitch_count;

  modport master (
    output locked,
    output soft_reset,
    input  reset_out_n,
    input  ready,
    input  state,
    input  lock_loss_count,
    input  glitch_count
  );

  modport slave (
    input  locked,
    input  soft_reset,
    output reset_out_n,
    output ready,
    output state,
    output lock_loss_count,
    output glitch_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Datapath reset generator for the PLL output clock domain: waits for lock to be stable,
// holds reset for a fixed interval, drops back to reset on lock loss, and counts lock events.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CNT_W              = 11
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  pll_reset_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [7:0]       SAT_MAX     = 8'hFF;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lockedS;
  state_t                 r_state;
  state_t                 w_nextState;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cntNext;
  logic                   w_glitchEvt;
  logic                   w_lockLossEvt;
  logic                   r_resetOutN;
  logic                   r_ready;
  logic [7:0]             r_lockLossCount;
  logic [7:0]             r_glitchCount;

  // locked is asynchronous to clock_in; this chain is its only sampling point
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.locked};
    end
  end

  assign w_lockedS = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_cntNext;
    end
  end

  // Lock loss is tested first in every state so it always beats soft_reset
  always_comb begin
    w_nextState   = r_state;
    w_cntNext     = r_cnt;
    w_glitchEvt   = 1'b0;
    w_lockLossEvt = 1'b0;
    case (r_state)
      IDLE: begin
        w_cntNext = '0;
        if (w_lockedS) begin
          w_nextState = STABILIZE;
        end
      end
      STABILIZE: begin
        if (!w_lockedS) begin
          w_nextState = IDLE;
          w_cntNext   = '0;
          w_glitchEvt = 1'b1;
        end else if (r_cnt == STABLE_LAST) begin
          w_nextState = HOLD;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + CNT_ONE;
        end
      end
      HOLD: begin
        if (!w_lockedS) begin
          w_nextState = IDLE;
          w_cntNext   = '0;
        end else if (bus.soft_reset) begin
          w_cntNext = '0;
        end else if (r_cnt == HOLD_LAST) begin
          w_nextState = RUN;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + CNT_ONE;
        end
      end
      RUN: begin
        w_cntNext = '0;
        if (!w_lockedS) begin
          w_nextState   = IDLE;
          w_lockLossEvt = 1'b1;
        end else if (bus.soft_reset) begin
          w_nextState = HOLD;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // Registered from next state so the reset edge coincides with the state change
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_resetOutN <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_resetOutN <= (w_nextState == RUN);
      r_ready     <= (w_nextState == RUN);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_lockLossCount <= '0;
      r_glitchCount   <= '0;
    end else begin
      if (w_lockLossEvt && (r_lockLossCount != SAT_MAX)) begin
        r_lockLossCount <= r_lockLossCount + 8'd1;
      end
      if (w_glitchEvt && (r_glitchCount != SAT_MAX)) begin
        r_glitchCount <= r_glitchCount + 8'd1;
      end
    end
  end

  assign bus.reset_out_n     = r_resetOutN;
  assign bus.ready           = r_ready;
  assign bus.state           = r_state;
  assign bus.lock_loss_count = r_lockLossCount;
  assign bus.glitch_count    = r_glitchCount;

endmodule
